// File: rtl/banco_registradores_sweep.sv
// rtl/banco_registradores_sweep.sv - parametrised register bank with byte-masked write, bypass and init sweep
// Two combinational read ports, one write port; a CLEAR sweep reloads every register after reset.
module banco_registradores_sweep #(
  parameter int SIZE         = 32,
  parameter int DEPTH        = 32,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  parameter int PRESET_A_IDX = 17,
  parameter int PRESET_A_VAL = 4,
  parameter int PRESET_B_IDX = 18,
  parameter int PRESET_B_VAL = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     Read1,
  input  logic [AW-1:0]     Read2,
  input  logic [AW-1:0]     WriteReg,
  input  logic [SIZE-1:0]   WriteData,
  input  logic [SIZE/8-1:0] ByteEn,
  input  logic              RegWrite,
  output logic [SIZE-1:0]   Data1,
  output logic [SIZE-1:0]   Data2,
  output logic              Busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic [SIZE-1:0]   r_regs [DEPTH];

  logic [SIZE-1:0]   w_init;
  logic [SIZE-1:0]   w_merged;
  logic              w_wr_en;
  logic              w_byp1;
  logic              w_byp2;

  always_comb begin
    w_init = '0;
    if (r_ptr == AW'(PRESET_A_IDX))
      w_init = SIZE'(PRESET_A_VAL);
    else if (r_ptr == AW'(PRESET_B_IDX))
      w_init = SIZE'(PRESET_B_VAL);
  end

  // Byte merge of the incoming word over the current contents of the target register.
  always_comb begin
    w_merged = r_regs[WriteReg];
    for (int i = 0; i < SIZE/8; i++) begin
      if (ByteEn[i])
        w_merged[8*i +: 8] = WriteData[8*i +: 8];
    end
  end

  assign w_wr_en = RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));
  assign w_byp1  = (BYPASS != 0) && w_wr_en && (WriteReg == Read1);
  assign w_byp2  = (BYPASS != 0) && w_wr_en && (WriteReg == Read2);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else if (r_state == CLEAR) begin
      r_regs[r_ptr] <= w_init;
      r_ptr         <= r_ptr + AW'(1);
      if (r_ptr == AW'(DEPTH-1))
        r_state <= READY;
    end else if (w_wr_en) begin
      r_regs[WriteReg] <= w_merged;
    end
  end

  assign Busy = (r_state == CLEAR);

  // Zeroing for busy and for register 0 takes priority over bypass.
  always_comb begin
    Data1 = w_byp1 ? w_merged : r_regs[Read1];
    Data2 = w_byp2 ? w_merged : r_regs[Read2];
    if (Busy || ((ZERO_REG != 0) && (Read1 == '0)))
      Data1 = '0;
    if (Busy || ((ZERO_REG != 0) && (Read2 == '0)))
      Data2 = '0;
  end

endmodule

// File: doc/banco_registradores_sweep.md
# banco_registradores_sweep

Parametrised successor to the MIPS register bank, sitting between decode and the ALU in the datapath. It is generalised in word width and register count, and provides two asynchronous read ports and one byte-masked write port. Register 0 is optionally hardwired to zero, and an optional write-to-read bypass is available. A synchronous-reset sweep FSM restores every register to a defined initial value, one register per cycle, and reports progress on `Busy`.

## Interface
Parameters:
- `SIZE`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 32: number of registers; power of two, at least 4.
- `AW`: localparam equal to $clog2(DEPTH); the width of the register index ports.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and writes to it are dropped.
- `BYPASS`, 1: when 1, a same-cycle write to a register being read is forwarded to the read port.
- `PRESET_A_IDX`, 17: index of the first preset register.
- `PRESET_A_VAL`, 4: value loaded into the first preset register by the sweep.
- `PRESET_B_IDX`, 18: index of the second preset register.
- `PRESET_B_VAL`, 1: value loaded into the second preset register by the sweep.

Ports:
- `clock`, in, 1: the single clock; all state updates on posedge.
- `reset`, in, 1: synchronous, active-high.
- `Read1`, in, AW: index for read port 1.
- `Read2`, in, AW: index for read port 2.
- `WriteReg`, in, AW: write index.
- `WriteData`, in, SIZE: write value.
- `ByteEn`, in, SIZE/8: per-byte write enable; bit i covers bits [8i+7:8i].
- `RegWrite`, in, 1: write request.
- `Data1`, out, SIZE: read data, port 1; combinational.
- `Data2`, out, SIZE: read data, port 2; combinational.
- `Busy`, out, 1: high while state is not READY.

## Operation
FSM has two states, CLEAR and READY. It uses a sweep pointer `ptr` of width AW.

Reset and sweep:
- Any posedge with `reset=1`: state goes to CLEAR, `ptr` goes to 0, and no register is written.
  - Reset held for N cycles keeps the FSM parked at `ptr=0`.
  - Reset asserted mid-sweep restarts the sweep from 0.
  - Reset asserted in READY starts a new sweep.
- Posedge in CLEAR with `reset=0`:
  - `reg[ptr]` is loaded with its init value: PRESET_A_VAL if `ptr==PRESET_A_IDX`, PRESET_B_VAL if `ptr==PRESET_B_IDX`, otherwise 0.
  - `ptr` increments.
  - If `ptr==DEPTH-1`, state goes to READY instead of continuing.
- Power-up state is undefined; a reset is mandatory before use.

Outputs and writes:
- `Busy` is 1 in CLEAR and 0 in READY.
- While `Busy=1`: `Data1` and `Data2` are forced to 0, and `RegWrite` is ignored (the write is dropped, not queued).

Write (READY only):
- At posedge with `RegWrite=1`, each byte i with `ByteEn[i]=1` takes the corresponding byte of `WriteData`. Other bytes are retained.
- `ByteEn=0` with `RegWrite=1` is a no-op.
- If `ZERO_REG=1` and `WriteReg==0`, the write is dropped.

Read (READY):
- `DataX` = `reg[ReadX]`.
- If `ZERO_REG=1` and `ReadX==0`, `DataX` = 0 regardless of storage or bypass.
- Bypass applies when `BYPASS=1`, `RegWrite=1`, `WriteReg==ReadX`, and the target is not the zeroed register 0. `DataX` is then the byte-merge of `WriteData` (enabled bytes) with `reg[ReadX]` (other bytes).
- Both ports may address the same register; each returns identical data.

## Timing
- Reset-to-ready latency: exactly DEPTH posedges with `reset=0` after the last posedge with `reset=1`. `Busy` falls after the DEPTH-th such edge.
- `Busy` reset value is 1, valid from the first edge with `reset=1`. `Data1`/`Data2` read 0 throughout reset and sweep.
- A write accepted at edge k is visible to reads:
  - in cycle k+1 when `BYPASS=0`;
  - combinationally in the same cycle before edge k when `BYPASS=1`.
- Read latency is 0 cycles (combinational from the `ReadX` and write inputs).
- `RegWrite` asserted in the same cycle that `reset=1` is dropped.
- `RegWrite` asserted in the cycle `Busy` falls (the first READY cycle) is accepted.

## Test plan
- Sweep (DEPTH=32): reset for 3 cycles, then release -> `Busy` stays 1 for 32 edges and then 0. Afterwards `Read1=17` gives 4, `Read2=18` gives 1, and registers 0-16 and 19-31 read 0.
- Reset mid-sweep: release reset, apply reset again at edge 10, then release -> `Busy` low only 32 edges after the second release. Writes attempted during the sweep (`WriteReg=5`, `WriteData=0xDEADBEEF`) leave reg 5 at 0.
- Byte mask: reg 3 = 0x11223344; write 0xAABBCCDD with `ByteEn=4'b0101` -> reg 3 reads 0x11BB33DD next cycle.
- Bypass (`BYPASS=1`): `RegWrite=1`, `WriteReg=7`, `WriteData=0x12345678`, full mask, `Read1=Read2=7` in the same cycle -> both ports read 0x12345678 before the edge. With `BYPASS=0` they read the old value until the next cycle.
- Zero register (`ZERO_REG=1`): write 0xFFFFFFFF to reg 0 with bypass active -> `Data1` reads 0 in the same cycle and after.
- Parameter sweep (SIZE=64, DEPTH=16, `PRESET_A_IDX=2`, `PRESET_A_VAL=9`, `PRESET_B_IDX=3`, `PRESET_B_VAL=1`): sweep takes 16 cycles, reg 2 reads 9, and an 8-bit `ByteEn` mask merge is correct.
